// File: rtl/collision_score.sv
// collision_score
//   Pixel-overlap collision detector and score keeper. It watches the per-object
//   pixel flags from the sprite managers along with the raster position. Once per
//   frame, at the end of the active area, it latches which bullets, rocks and the
//   ship were involved in a collision. It also updates a saturating score and a
//   sticky game-over flag.
//
//   Optional feature macro: COLLIDE_BCD_EN
//     defined     : oScore holds 4 packed BCD digits. The score is added one rock per
//                   cycle after end-of-frame. oFrame_tick fires when the add finishes.
//     not defined : oScore is binary, zero-extended. oFrame_tick fires the cycle
//                   after end-of-frame.
//
// Ports
//   iCLK, iRST_N   pixel clock, async active-low reset
//   px, py         raster coordinates (py >= V_ACTIVE is vertical blank)
//   iShip_pix      ship pixel present at (px,py)
//   iBullet_pix    bullet pixels present at (px,py)
//   iRock_pix      rock pixels present at (px,py)
//   iClear         synchronous new-game strobe
//   oBullet_hit    bullets that touched a rock last frame
//   oRock_hit      rocks that touched a bullet last frame
//   oShip_hit      ship touched a rock last frame
//   oFrame_tick    one-cycle pulse when the hit outputs and the score are fresh
//   oScore         score
//   oGame_over     sticky game-over flag
module collision_score #(
    parameter int NB        = 4,
    parameter int NR        = 10,
    parameter int V_ACTIVE  = 480,
    parameter int SCORE_MAX = 9999
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic [9:0]    px,
    input  logic [9:0]    py,
    input  logic          iShip_pix,
    input  logic [NB-1:0] iBullet_pix,
    input  logic [NR-1:0] iRock_pix,
    input  logic          iClear,
    output logic [NB-1:0] oBullet_hit,
    output logic [NR-1:0] oRock_hit,
    output logic          oShip_hit,
    output logic          oFrame_tick,
    output logic [15:0]   oScore,
    output logic          oGame_over
);

    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

    typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

    // Input stage: every decision below uses these registered copies.
    logic [9:0]    px_q, py_q, py_prev_q;
    logic          ship_q;
    logic [NB-1:0] bul_q;
    logic [NR-1:0] rock_q;

    // Collision position does not matter, so the raster X is only carried along.
    logic unused_px;
    assign unused_px = ^px_q;

    logic active, eof;
    assign active = (py_q < V_ACT);
    // This is the first cycle in blank after an active line. It happens exactly once per frame.
    assign eof    = (py_prev_q < V_ACT) && !active;

    state_t        state_q, state_d;
    logic [NB-1:0] b_acc_q, b_acc_d, bhit_q, bhit_d;
    logic [NR-1:0] r_acc_q, r_acc_d, rhit_q, rhit_d;
    logic          s_acc_q, s_acc_d, shit_q, shit_d;
    logic          tick_q, tick_d;
    logic [15:0]   score_q, score_d;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            px_q      <= '0;
            py_q      <= '0;
            py_prev_q <= '0;
            ship_q    <= 1'b0;
            bul_q     <= '0;
            rock_q    <= '0;
        end else begin
            px_q      <= px;
            py_q      <= py;
            py_prev_q <= py_q;
            ship_q    <= iShip_pix;
            bul_q     <= iBullet_pix;
            rock_q    <= iRock_pix;
        end
    end

    // Game state
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= PLAY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (iClear)
            state_d = PLAY;
        else if (eof && (state_q == PLAY) && s_acc_q)
            state_d = OVER;
    end

    // Accumulators and per-frame hit flags.
    // An overlap is only counted across object classes. Rock-on-rock and
    // bullet-on-bullet overlaps are ignored.
    always_comb begin
        b_acc_d = b_acc_q;
        r_acc_d = r_acc_q;
        s_acc_d = s_acc_q;
        bhit_d  = bhit_q;
        rhit_d  = rhit_q;
        shit_d  = shit_q;
        if (iClear) begin
            // The clear takes priority over a coincident EOF, so that frame's hits are dropped.
            b_acc_d = '0;
            r_acc_d = '0;
            s_acc_d = 1'b0;
            bhit_d  = '0;
            rhit_d  = '0;
            shit_d  = 1'b0;
        end else if (eof) begin
            bhit_d  = b_acc_q;
            rhit_d  = r_acc_q;
            shit_d  = s_acc_q;
            b_acc_d = '0;
            r_acc_d = '0;
            s_acc_d = 1'b0;
        end else if (active) begin
            b_acc_d = b_acc_q | (bul_q  & {NB{|rock_q}});
            r_acc_d = r_acc_q | (rock_q & {NR{|bul_q}});
            s_acc_d = s_acc_q | (ship_q & (|rock_q));
        end
    end

`ifdef COLLIDE_BCD_EN
    localparam int CW = (NR > 1) ? $clog2(NR) : 1;

    // Adds one to a BCD score, with a carry between digits. The score holds at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        c;
        r = s;
        c = 1'b1;
        if (s != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (c) begin
                    if (r[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // After EOF the rock flags are shifted out one per cycle. Each set flag bumps the score.
    logic [NR-1:0] seq_q, seq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    always_comb begin
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        score_d = score_q;
        tick_d  = 1'b0;
        if (iClear) begin
            seq_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            score_d = '0;
        end else if (eof) begin
            // After game over the walk still runs so the tick keeps the same timing. The mask stops any adds.
            seq_d  = (state_q == PLAY) ? r_acc_q : '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (seq_q[0]) score_d = bcd_inc(score_q);
            seq_d = seq_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NR - 1)) begin
                busy_d = 1'b0;
                tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            seq_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
`else
    localparam int PCW = $clog2(NR + 1);

    function automatic logic [PCW-1:0] popcnt(input logic [NR-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int k = 0; k < NR; k++) c = c + PCW'(v[k]);
        return c;
    endfunction

    logic [15:0] sum_w;
    assign sum_w = score_q + 16'(popcnt(r_acc_q));

    always_comb begin
        score_d = score_q;
        tick_d  = 1'b0;
        if (iClear) begin
            score_d = '0;
        end else if (eof) begin
            tick_d = 1'b1;
            if (state_q == PLAY)
                score_d = (sum_w > 16'(SCORE_MAX)) ? 16'(SCORE_MAX) : sum_w;
        end
    end
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            b_acc_q <= '0;
            r_acc_q <= '0;
            s_acc_q <= 1'b0;
            bhit_q  <= '0;
            rhit_q  <= '0;
            shit_q  <= 1'b0;
            tick_q  <= 1'b0;
            score_q <= '0;
        end else begin
            b_acc_q <= b_acc_d;
            r_acc_q <= r_acc_d;
            s_acc_q <= s_acc_d;
            bhit_q  <= bhit_d;
            rhit_q  <= rhit_d;
            shit_q  <= shit_d;
            tick_q  <= tick_d;
            score_q <= score_d;
        end
    end

    assign oBullet_hit = bhit_q;
    assign oRock_hit   = rhit_q;
    assign oShip_hit   = shit_q;
    assign oFrame_tick = tick_q;
    assign oScore      = score_q;
    assign oGame_over  = (state_q == OVER);

endmodule

// File: tb/tb_collision_score.sv
// Testbench for collision_score. A compressed raster drives a few active pixels
// and then a blanking stretch. A frame-level model predicts the hit flags, the
// score and the game-over state. A monitor checks each prediction on oFrame_tick.
module tb_collision_score;

    localparam int NB = 4;
    localparam int NR = 10;
    localparam int NBLANK = 16;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic [9:0]    px = '0, py = '0;
    logic          iShip_pix = 1'b0;
    logic [NB-1:0] iBullet_pix = '0;
    logic [NR-1:0] iRock_pix = '0;
    logic          iClear = 1'b0;
    logic [NB-1:0] oBullet_hit;
    logic [NR-1:0] oRock_hit;
    logic          oShip_hit, oFrame_tick, oGame_over;
    logic [15:0]   oScore;

    collision_score #(.NB(NB), .NR(NR), .V_ACTIVE(480), .SCORE_MAX(9999)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .px(px), .py(py),
        .iShip_pix(iShip_pix), .iBullet_pix(iBullet_pix), .iRock_pix(iRock_pix),
        .iClear(iClear), .oBullet_hit(oBullet_hit), .oRock_hit(oRock_hit),
        .oShip_hit(oShip_hit), .oFrame_tick(oFrame_tick), .oScore(oScore),
        .oGame_over(oGame_over)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [NB-1:0] b;
        logic [NR-1:0] r;
        logic          s;
        logic [15:0]   score;
        logic          go;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Frame-level model state
    logic [NB-1:0] mb;
    logic [NR-1:0] mr;
    logic          ms;
    int            m_score;
    logic          m_go;

    function automatic logic [15:0] enc(input int s);
`ifdef COLLIDE_BCD_EN
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
`else
        return 16'(s);
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        mb = '0; mr = '0; ms = 1'b0; m_score = 0; m_go = 1'b0;
    endtask

    // Drive one pixel. Overlaps at active lines go into the model.
    task automatic drive(input logic [9:0] y, input logic s, input logic [NB-1:0] b,
                         input logic [NR-1:0] r);
        @(posedge iCLK); #1;
        px = 10'($urandom_range(0, 639));
        py = y; iShip_pix = s; iBullet_pix = b; iRock_pix = r;
        if (y < 10'd480) begin
            if (b != 0 && r != 0) begin mb = mb | b; mr = mr | r; end
            if (s && r != 0) ms = 1'b1;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.b = mb; e.r = mr; e.s = ms;
        if (!m_go) begin
            m_score = m_score + $countones(mr);
            if (m_score > 9999) m_score = 9999;
            if (ms) m_go = 1'b1;
        end
        e.score = enc(m_score);
        e.go = m_go;
        exp_q.push_back(e);
        mb = '0; mr = '0; ms = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bullet"}, 32'(oBullet_hit), 32'd0);
        check({tag, "_rock"},   32'(oRock_hit),   32'd0);
        check({tag, "_ship"},   32'(oShip_hit),   32'd0);
        check({tag, "_tick"},   32'(oFrame_tick), 32'd0);
        check({tag, "_score"},  32'(oScore),      32'd0);
        check({tag, "_over"},   32'(oGame_over),  32'd0);
    endtask

    // Blank interval. Every object overlaps here on purpose, and all of it must be ignored.
    task automatic end_frame(input bit clr);
        drive(10'($urandom_range(480, 524)), 1'b1, '1, '1);
        if (clr) begin
            @(posedge iCLK); #1;
            iClear = 1'b1; py = 10'd490;
            @(posedge iCLK); #1;
            iClear = 1'b0;
            model_clear();
            check_idle("clear");
        end else begin
            push_expected();
        end
        for (int k = 0; k < NBLANK; k++)
            drive(10'($urandom_range(480, 524)), 1'b1, '1, '1);
    endtask

    task automatic rand_frame(input int nact);
        for (int k = 0; k < nact; k++)
            drive(10'($urandom_range(0, 479)), ($urandom_range(0, 15) == 0),
                  NB'($urandom) & NB'($urandom), NR'($urandom) & NR'($urandom) & NR'($urandom));
        end_frame(1'b0);
    endtask

    task automatic clean_frame();
        drive(10'd10, 1'b1, '0, '0);
        drive(10'd11, 1'b0, '1, '0);
        drive(10'd12, 1'b0, '0, '1);
        end_frame(1'b0);
    endtask

    // Monitor: every tick pops one prediction.
    always @(negedge iCLK) begin
        if (iRST_N && oFrame_tick) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_tick: got tick expected none at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bullet_hit", 32'(oBullet_hit), 32'(e.b));
                check("rock_hit",   32'(oRock_hit),   32'(e.r));
                check("ship_hit",   32'(oShip_hit),   32'(e.s));
                check("score",      32'(oScore),      32'(e.score));
                check("game_over",  32'(oGame_over),  32'(e.go));
            end
        end
    end

    initial begin
        model_clear();
        repeat (3) @(posedge iCLK);
        #1 check_idle("reset");
        iRST_N = 1'b1;

        // Two clean frames
        clean_frame();
        clean_frame();

        // Bullet 2 on rock 7 for three pixels, then a clean frame
        for (int k = 0; k < 3; k++) drive(10'(100 + k), 1'b0, 4'b0100, 10'b00_1000_0000);
        end_frame(1'b0);
        clean_frame();

        // Bullet 0 on rocks 1, 3 and 5 (+3). Overlaps during blank must be ignored.
        drive(10'd200, 1'b0, 4'b0001, 10'b00_0000_0010);
        drive(10'd201, 1'b0, 4'b0001, 10'b00_0000_1000);
        drive(10'd202, 1'b0, 4'b0001, 10'b00_0010_0000);
        end_frame(1'b0);

        for (int f = 0; f < 20; f++) rand_frame(6);

        // Clear exactly on EOF after an overlap
        drive(10'd50, 1'b1, 4'b1000, 10'b00_0000_0001);
        end_frame(1'b1);
        clean_frame();

        // Run the score up to 9998, then a ship hit plus two rocks saturates it
        for (int f = 0; f < 999; f++) begin
            drive(10'd100, 1'b0, 4'b0001, '1);
            end_frame(1'b0);
        end
        drive(10'd100, 1'b0, 4'b0001, 10'h0FF);
        end_frame(1'b0);
        drive(10'd100, 1'b1, 4'b0000, 10'b00_0000_0001);
        drive(10'd101, 1'b0, 4'b0001, 10'b00_0101_0000);
        end_frame(1'b0);
        // Game is over: hits are still reported, the score stays frozen
        drive(10'd100, 1'b0, 4'b0010, 10'b11_0000_0000);
        end_frame(1'b0);
        for (int f = 0; f < 3; f++) rand_frame(6);

        // New game
        drive(10'd60, 1'b0, 4'b0001, 10'b00_0000_0001);
        end_frame(1'b1);
        for (int f = 0; f < 5; f++) rand_frame(6);

        // Reset in the middle of a frame while overlaps are pending
        drive(10'd30, 1'b1, 4'b1111, 10'h3FF);
        drive(10'd31, 1'b0, 4'b0011, 10'h00F);
        #2 iRST_N = 1'b0;
        py = '0; iShip_pix = 1'b0; iBullet_pix = '0; iRock_pix = '0;
        model_clear();
        #1 check_idle("midreset");
        #6 iRST_N = 1'b1;
        drive(10'd40, 1'b0, 4'b0100, 10'b10_0000_0000);
        end_frame(1'b0);
        for (int f = 0; f < 10; f++) rand_frame(8);

        // Let the last ticks drain, with a bounded wait
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge iCLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
